// File: rtl/grf_hazard_ctrl_pkg.sv
// Shared encodings, defaults and the stage-tracking record for the decode-stage
// hazard scheduler.
package grf_hazard_ctrl_pkg;

    // Forwarding select encodings for a D-stage source operand
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } trk_t;

    localparam trk_t TRK_EMPTY = '{dst: 5'd0, tnew: 2'd0};

    // Result latency one stage later; a ready result stays ready
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x != 2'd0) ? x - 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/grf_hazard_ctrl_if.sv
// Decode-stage view of the hazard scheduler: operand/destination descriptors in,
// stall/flush/forward selects and MD busy out.
interface grf_hazard_ctrl_if;

    // Decode presents one instruction every cycle; it issues on a rising edge
    // where stall is low, otherwise it is held and E receives a bubble.
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] rs_tuse_D;
    logic [1:0] rt_tuse_D;
    logic [4:0] dst_D;
    logic [1:0] tnew_D;
    logic       md_start_D;
    logic       md_div_D;
    logic       md_use_D;

    logic       stall;
    logic       flush_E;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       md_busy;

    modport master (
        output rs_D, rt_D, rs_tuse_D, rt_tuse_D, dst_D, tnew_D,
               md_start_D, md_div_D, md_use_D,
        input  stall, flush_E, fwd_rs, fwd_rt, md_busy
    );

    modport slave (
        input  rs_D, rt_D, rs_tuse_D, rt_tuse_D, dst_D, tnew_D,
               md_start_D, md_div_D, md_use_D,
        output stall, flush_E, fwd_rs, fwd_rt, md_busy
    );

endinterface

// File: rtl/grf_hazard_ctrl_md_busy_cnt.sv
// Multiply/divide busy counter: loads the operation latency on issue and counts
// down to zero; busy while nonzero.
module grf_hazard_ctrl_md_busy_cnt
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/grf_hazard_ctrl.sv
// Decode-stage hazard scheduler: tracks pending writes in E/M/W, derives stall,
// E bubble and forwarding selects, and gates HI/LO users on the MD unit.
module grf_hazard_ctrl
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    grf_hazard_ctrl_if.slave   bus
);

    trk_t       e_q;
    trk_t       m_q;
    // A W-stage result is always ready, so only its destination is kept
    logic [4:0] w_dst_q;

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic stall_c;
    logic md_busy_w;
    logic md_load;

    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // Nearest producer decides: an E match shadows any M match
    function automatic logic data_stall(input logic [4:0] src, input logic [1:0] tuse,
                                        input trk_t e, input trk_t m);
        if (tuse == TUSE_NONE) return 1'b0;
        if (hit(src, e.dst)) return e.tnew > tuse;
        return hit(src, m.dst) && (m.tnew > tuse);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input trk_t e,
                                           input trk_t m, input logic [4:0] w_dst);
        if (hit(src, e.dst) && e.tnew == 2'd0) return FWD_E;
        if (hit(src, m.dst) && m.tnew == 2'd0) return FWD_M;
        if (hit(src, w_dst)) return FWD_W;
        return FWD_GRF;
    endfunction

    always_comb begin
        rs_stall = data_stall(bus.rs_D, bus.rs_tuse_D, e_q, m_q);
        rt_stall = data_stall(bus.rt_D, bus.rt_tuse_D, e_q, m_q);
        md_stall = bus.md_use_D && md_busy_w;
        stall_c  = rs_stall || rt_stall || md_stall;
        md_load  = bus.md_start_D && !stall_c;
    end

    assign bus.stall   = stall_c;
    assign bus.flush_E = stall_c;
    assign bus.fwd_rs  = fwd_sel(bus.rs_D, e_q, m_q, w_dst_q);
    assign bus.fwd_rt  = fwd_sel(bus.rt_D, e_q, m_q, w_dst_q);
    assign bus.md_busy = md_busy_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= TRK_EMPTY;
            m_q     <= TRK_EMPTY;
            w_dst_q <= 5'd0;
        end else begin
            w_dst_q <= m_q.dst;
            m_q     <= '{dst: e_q.dst, tnew: sat_dec(e_q.tnew)};
            e_q     <= stall_c ? TRK_EMPTY : '{dst: bus.dst_D, tnew: bus.tnew_D};
        end
    end

    grf_hazard_ctrl_md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .div   (bus.md_div_D),
        .busy  (md_busy_w)
    );

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Bench for grf_hazard_ctrl: directed pipeline scenarios plus randomized traffic
// against an age-based in-flight instruction model.
module tb_grf_hazard_ctrl;
    import grf_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    grf_hazard_ctrl_if bus();

    grf_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: in-flight instructions by age (0 = E, 1 = M, 2 = W) with their
    // original latency; MD busy is an absolute cycle deadline.
    int m_dst[3];
    int m_tnew[3];
    int cyc;
    int busy_until;

    function automatic int left_after(int tnew, int age);
        return (tnew - age > 0) ? tnew - age : 0;
    endfunction

    function automatic bit exp_src_stall(int src, int tuse);
        if (tuse == 3 || src == 0) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (m_dst[a] == src) return left_after(m_tnew[a], a) > tuse;
        return 1'b0;
    endfunction

    function automatic int exp_fwd(int src);
        if (src == 0) return 0;
        for (int a = 0; a < 2; a++)
            if (m_dst[a] == src && left_after(m_tnew[a], a) == 0) return a + 1;
        if (m_dst[2] == src) return 3;
        return 0;
    endfunction

    function automatic bit exp_md_busy();
        return cyc < busy_until;
    endfunction

    function automatic bit exp_stall();
        return exp_src_stall(int'(bus.rs_D), int'(bus.rs_tuse_D)) ||
               exp_src_stall(int'(bus.rt_D), int'(bus.rt_tuse_D)) ||
               (bus.md_use_D && exp_md_busy());
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            m_dst[a]  = 0;
            m_tnew[a] = 0;
        end
        cyc        = 0;
        busy_until = 0;
    endtask

    task automatic drive(input int rs, input int rs_tuse, input int rt, input int rt_tuse,
                         input int dst, input int tnew, input bit md_start,
                         input bit md_div, input bit md_use);
        bus.rs_D       = 5'(rs);
        bus.rs_tuse_D  = 2'(rs_tuse);
        bus.rt_D       = 5'(rt);
        bus.rt_tuse_D  = 2'(rt_tuse);
        bus.dst_D      = 5'(dst);
        bus.tnew_D     = 2'(tnew);
        bus.md_start_D = md_start;
        bus.md_div_D   = md_div;
        bus.md_use_D   = md_use;
    endtask

    task automatic idle();
        drive(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: advance the model with the current D inputs, return at negedge
    task automatic tick();
        bit s;
        s = exp_stall();
        @(posedge clk);
        m_dst[2]  = m_dst[1];
        m_tnew[2] = m_tnew[1];
        m_dst[1]  = m_dst[0];
        m_tnew[1] = m_tnew[0];
        m_dst[0]  = s ? 0 : int'(bus.dst_D);
        m_tnew[0] = s ? 0 : int'(bus.tnew_D);
        if (bus.md_start_D && !s) busy_until = cyc + 1 + (bus.md_div_D ? 10 : 5);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(5, 0, 6, 0, 7, 2, 1'b1, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_E, bus.fwd_rs, bus.fwd_rt, bus.md_busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected 0000000",
                     {bus.stall, bus.flush_E, bus.fwd_rs, bus.fwd_rt, bus.md_busy});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle();
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle stall=%b md_busy=%b expected 0 0", bus.stall, bus.md_busy);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(0, 3, 0, 3, 8, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8, 1, 0, 3, 0, 1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.stall !== 1'b1 || bus.flush_E !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_E stall=%b flush_E=%b expected 1 1", bus.stall, bus.flush_E);
        end
        tick();
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_rs !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_M stall=%b fwd_rs=%0d expected 0 0", bus.stall, bus.fwd_rs);
        end
        tick();
        // Branch consumer (tuse 0) waits through E and M, then takes W
        drive(0, 3, 0, 3, 10, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        drive(10, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (bus.stall !== 1'b1) begin
                n_fail++;
                $display("FAIL load_branch_stall%0d stall=%b expected 1", k, bus.stall);
            end
            tick();
        end
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_rs !== FWD_W) begin
            n_fail++;
            $display("FAIL load_branch_W stall=%b fwd_rs=%0d expected 0 3", bus.stall, bus.fwd_rs);
        end
        tick();
    endtask

    task automatic test_alu_chain();
        drive(0, 3, 0, 3, 9, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 3, 9, 1, 0, 1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_rt !== 2'd0) begin
            n_fail++;
            $display("FAIL alu_in_E stall=%b fwd_rt=%0d expected 0 0", bus.stall, bus.fwd_rt);
        end
        tick();
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_rt !== FWD_M) begin
            n_fail++;
            $display("FAIL alu_in_M stall=%b fwd_rt=%0d expected 0 2", bus.stall, bus.fwd_rt);
        end
        tick();
        drive(9, 1, 9, 1, 0, 1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.fwd_rs !== FWD_W || bus.fwd_rt !== FWD_W || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL same_src_W fwd_rs=%0d fwd_rt=%0d stall=%b expected 3 3 0",
                     bus.fwd_rs, bus.fwd_rt, bus.stall);
        end
        tick();
    endtask

    task automatic test_jal_and_zero();
        drive(0, 3, 0, 3, 31, TNEW_JAL, 1'b0, 1'b0, 1'b0);
        tick();
        drive(31, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_rs !== FWD_E) begin
            n_fail++;
            $display("FAIL jal_fwd stall=%b fwd_rs=%0d expected 0 1", bus.stall, bus.fwd_rs);
        end
        tick();
        drive(0, 3, 0, 3, 0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0 || bus.fwd_rs !== 2'd0 || bus.fwd_rt !== 2'd0) begin
            n_fail++;
            $display("FAIL zero_reg stall=%b fwd_rs=%0d fwd_rt=%0d expected 0 0 0",
                     bus.stall, bus.fwd_rs, bus.fwd_rt);
        end
        tick();
    endtask

    task automatic test_md_sequence();
        int n;
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL div_issue stall=%b expected 0", bus.stall);
        end
        tick();
        drive(0, 3, 0, 3, 4, 1, 1'b0, 1'b0, 1'b1);
        n = 0;
        #1;
        while (bus.stall === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL mfhi_stall_len got %0d cycles expected 10", n);
        end
        tick();
        // mult right behind a div waits out the divide, then reloads
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b0, 1'b1);
        n = 0;
        #1;
        while (bus.stall === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL mult_b2b_stall_len got %0d cycles expected 10", n);
        end
        tick();
        idle();
        n = 0;
        #1;
        while (bus.md_busy === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL mult_busy_len got %0d cycles expected 5", n);
        end
        // Data and MD stall together: one stall, and E must take a bubble
        drive(0, 3, 0, 3, 12, TNEW_LOAD, 1'b1, 1'b0, 1'b1);
        tick();
        drive(12, 1, 0, 3, 13, 0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.stall !== 1'b1 || bus.flush_E !== 1'b1) begin
            n_fail++;
            $display("FAIL data_md_stall stall=%b flush_E=%b expected 1 1", bus.stall, bus.flush_E);
        end
        tick();
        drive(13, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.fwd_rs !== 2'd0) begin
            n_fail++;
            $display("FAIL bubble_in_E fwd_rs=%0d expected 0", bus.fwd_rs);
        end
        tick();
        idle();
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_async_reset();
        drive(0, 3, 0, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        tick();
        drive(0, 3, 0, 3, 7, TNEW_ALU, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        drive(7, 0, 7, 3, 0, 0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.md_busy !== 1'b1 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy md_busy=%b stall=%b expected 1 1", bus.md_busy, bus.stall);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0 || bus.fwd_rs !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset md_busy=%b stall=%b fwd_rs=%0d expected 0 0 0",
                     bus.md_busy, bus.stall, bus.fwd_rs);
        end
        #1;
        reset = 1'b0;
        model_reset();
        tick();
        #1;
        n_checks++;
        if (bus.md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL counter_cleared md_busy=%b expected 0", bus.md_busy);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        bit s;
        int er, et;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'b0, 1'($urandom_range(0, 1)), 1'b0);
            bus.md_start_D = ($urandom_range(0, 7) == 0);
            bus.md_use_D   = bus.md_start_D || ($urandom_range(0, 3) == 0);
            #1;
            s  = exp_stall();
            er = exp_fwd(int'(bus.rs_D));
            et = exp_fwd(int'(bus.rt_D));
            n_checks++;
            if (bus.stall !== s || bus.flush_E !== s) begin
                n_fail++;
                $display("FAIL rand_stall i=%0d stall=%b flush_E=%b expected %b", i, bus.stall, bus.flush_E, s);
            end
            n_checks++;
            if (bus.fwd_rs !== 2'(er) || bus.fwd_rt !== 2'(et)) begin
                n_fail++;
                $display("FAIL rand_fwd i=%0d fwd_rs=%0d fwd_rt=%0d expected %0d %0d",
                         i, bus.fwd_rs, bus.fwd_rt, er, et);
            end
            n_checks++;
            if (bus.md_busy !== exp_md_busy()) begin
                n_fail++;
                $display("FAIL rand_md_busy i=%0d md_busy=%b expected %b", i, bus.md_busy, exp_md_busy());
            end
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        model_reset();
        idle();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_alu_chain();
        test_jal_and_zero();
        test_md_sequence();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
